// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types for the counter-game stimulus engine
package game_pkg;

  // Widest INIT_l the command record can carry; game_player uses the low SIZE bits.
  localparam int VALUE_W = 16;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } control_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } who_e;

  typedef struct packed {
    control_e             mode;
    logic                 load;
    logic [VALUE_W-1:0]   value;
    logic [7:0]           cycles;
  } player_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_OVER,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/game_cmd_fifo.sv
// rtl/game_cmd_fifo.sv - synchronous command FIFO with flush; flush beats a same-cycle push
module game_cmd_fifo
  import game_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  player_cmd_t push_data,
  input  logic        pop,
  input  logic        flush,
  output player_cmd_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  player_cmd_t      mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/game_player.sv
// rtl/game_player.sv - queued stimulus engine for the counter game; optional GAME_PLAYER_STATS_EN
module game_player
  import game_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int MAX_SCORE  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic                 cmd_load,
  input  logic [SIZE-1:0]      cmd_value,
  input  logic [7:0]           cmd_cycles,
  output logic [1:0]           control,
  output logic [SIZE-1:0]      INIT_l,
  output logic                 INIT_c,
  input  logic                 GAMEOVER,
  input  logic [1:0]           WHO,
  output logic                 game_reset,
  output logic                 result_valid,
  output logic [1:0]           result_who,
`ifdef GAME_PLAYER_STATS_EN
  output logic [MAX_SCORE-1:0] wins,
  output logic [MAX_SCORE-1:0] losses,
`endif
  output logic                 underrun
);

  localparam int CW = $clog2(CLR_CYCLES + 1);

  state_e          state, state_d;
  player_cmd_t     push_cmd, head;
  logic            full, empty, push, pop, flush;
  control_e        cur_mode;
  logic [SIZE-1:0] cur_value;
  logic [7:0]      hold_cnt;
  logic [CW-1:0]   clr_cnt;
  logic            played;
  logic            unused_head;

  assign cmd_ready   = !full && (state != S_OVER) && (state != S_CLEAR) && !GAMEOVER;
  assign push        = cmd_valid && cmd_ready;
  assign unused_head = ^head.value;

  always_comb begin
    push_cmd                  = '0;
    push_cmd.mode             = control_e'(cmd_mode);
    push_cmd.load             = cmd_load;
    push_cmd.value[SIZE-1:0]  = cmd_value;
    push_cmd.cycles           = cmd_cycles;
  end

  game_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state)
      S_IDLE, S_LOAD, S_RUN: begin
        if (GAMEOVER) begin
          flush   = 1'b1;
          state_d = S_OVER;
        end else if (state == S_IDLE || (state == S_RUN && hold_cnt == 8'd0)) begin
          // End of a hold chains straight into the next queued command.
          if (!empty) begin
            pop     = 1'b1;
            state_d = head.load ? S_LOAD : S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end else if (state == S_LOAD) begin
          state_d = S_RUN;
        end
      end
      S_OVER:  if (clr_cnt == CW'(CLR_CYCLES - 1)) state_d = S_CLEAR;
      S_CLEAR: if (!GAMEOVER) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      control      <= 2'b00;
      INIT_l       <= '0;
      INIT_c       <= 1'b0;
      game_reset   <= 1'b0;
      result_valid <= 1'b0;
      result_who   <= 2'b00;
      underrun     <= 1'b0;
      cur_mode     <= UP1;
      cur_value    <= '0;
      hold_cnt     <= '0;
      clr_cnt      <= '0;
      played       <= 1'b0;
    end else begin
      state        <= state_d;
      INIT_c       <= 1'b0;
      result_valid <= 1'b0;
      if (pop) begin
        cur_mode  <= head.mode;
        cur_value <= head.value[SIZE-1:0];
        hold_cnt  <= head.cycles;
        played    <= 1'b1;
      end
      case (state)
        S_IDLE:  if (!GAMEOVER && empty && played) underrun <= 1'b1;
        S_LOAD:  if (!GAMEOVER) begin
                   INIT_c <= 1'b1;
                   INIT_l <= cur_value;
                 end
        S_RUN:   if (!GAMEOVER) begin
                   control <= cur_mode;
                   if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
                 end
        S_OVER:  begin
                   game_reset <= 1'b1;
                   control    <= UP1;
                   clr_cnt    <= clr_cnt + CW'(1);
                 end
        S_CLEAR: begin
                   game_reset <= 1'b0;
                   clr_cnt    <= '0;
                   if (!GAMEOVER) control <= UP1;
                 end
        default: ;
      endcase
      if (flush) begin
        result_valid <= 1'b1;
        result_who   <= WHO;
        underrun     <= 1'b0;
        played       <= 1'b0;
      end
    end
  end

`ifdef GAME_PLAYER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wins   <= '0;
      losses <= '0;
    end else if (flush) begin
      if (WHO == WIN && wins != '1)    wins   <= wins + MAX_SCORE'(1);
      if (WHO == LOSE && losses != '1) losses <= losses + MAX_SCORE'(1);
    end
  end
`else
  localparam int unused_max_score = MAX_SCORE;
`endif

endmodule
